vend_fsm: RTL and testbench

- Purchase controller for the vending machine. Sits directly downstream of the button decoder, which supplies price code and food type.
- Accumulates coin credit in nickel units and arbitrates each selection as purchase or rejection.
- Returns change or refunds as serialized dime/nickel pulses.
- Drives the display and LED stage with state, balance and one-cycle event pulses.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_hold_timer.sv | 30 +++
 rtl/vend_fsm.sv | 161 ++++++++++++++++
 tb/tb_vend_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine purchase controller.
package vend_pkg;

  // Controller states; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    INIT      = 3'd0,
    MONEY     = 3'd1,
    PURCHASED = 3'd2,
    REJECTION = 3'd3,
    REFUND    = 3'd4
  } state_t;

  // Coin values in nickel units.
  localparam logic [4:0] NICKEL_VAL = 5'd1;
  localparam logic [4:0] DIME_VAL   = 5'd2;

  // Item price in nickels: 5*(cost+1), i.e. 25c..$1.00.
  function automatic logic [4:0] price_nickels(input logic [1:0] cost);
    logic [4:0] c;
    c = {3'b000, cost} + 5'd1;
    return (c << 2) + c;
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// Loadable down-counter that times the REJECTION hold.
// done is high while the count is zero, i.e. in the last cycle of the hold.
module vend_hold_timer #(
  parameter int HOLD = 100
) (
  input  logic hz100,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(HOLD + 1);

  logic [W-1:0] count;

  // Load HOLD-1 on entry so that done rises after exactly HOLD cycles.
  always_ff @(posedge hz100) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(HOLD - 1);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/vend_fsm.sv
// Purchase controller: accumulates coin credit, arbitrates selections,
// and serialises change/refunds as dime and nickel pulses.
module vend_fsm
  import vend_pkg::*;
#(
  parameter int MAX_BAL     = 30,
  parameter int REJECT_HOLD = 100
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic       coin_nickel,
  input  logic       coin_dime,
  input  logic       sel_valid,
  input  logic [1:0] sel_cost,
  input  logic [1:0] sel_type,
  input  logic       cancel,
  output logic [2:0] state,
  output logic [4:0] balance,
  output logic       dispense,
  output logic [1:0] dispense_type,
  output logic       reject,
  output logic       coin_return,
  output logic       change_dime,
  output logic       change_nickel
);

  state_t     st;
  logic [4:0] coin_val;
  logic       coin_any;
  logic [5:0] bal_plus;
  logic       coin_fits;
  logic [4:0] bal_credit;
  logic [4:0] price;
  logic       afford;
  logic       enter_rej;
  logic       hold_done;

  assign state = st;

  // Coin value, overflow check, price compare and REJECTION entry detect.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    enter_rej  = 1'b0;
    coin_val   = (coin_nickel ? NICKEL_VAL : 5'd0) + (coin_dime ? DIME_VAL : 5'd0);
    coin_any   = coin_nickel | coin_dime;
    bal_plus   = {1'b0, balance} + {1'b0, coin_val};
    coin_fits  = (bal_plus <= 6'(MAX_BAL));
    bal_credit = (coin_any && coin_fits) ? bal_plus[4:0] : balance;
    price      = price_nickels(sel_cost);
    afford     = (price <= balance);
    case (st)
      INIT:    enter_rej = sel_valid;
      MONEY:   enter_rej = sel_valid && !cancel && !afford;
      default: enter_rej = 1'b0;
    endcase
  end

  vend_hold_timer #(
    .HOLD (REJECT_HOLD)
  ) u_hold (
    .hz100 (hz100),
    .reset (reset),
    .load  (enter_rej),
    .en    (st == REJECTION),
    .done  (hold_done)
  );

  // Main controller: state, balance and all registered outputs.
  always_ff @(posedge hz100) begin
    if (reset) begin
      st            <= INIT;
      balance       <= 5'd0;
      dispense      <= 1'b0;
      dispense_type <= 2'd0;
      reject        <= 1'b0;
      coin_return   <= 1'b0;
      change_dime   <= 1'b0;
      change_nickel <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      dispense      <= 1'b0;
      coin_return   <= 1'b0;
      change_dime   <= 1'b0;
      change_nickel <= 1'b0;
      case (st)
        INIT: begin
          if (sel_valid) begin
            // Zero credit is below every price.
            st          <= REJECTION;
            reject      <= 1'b1;
            coin_return <= coin_any;
          end else if (coin_any) begin
            if (coin_fits) begin
              balance <= bal_plus[4:0];
              st      <= MONEY;
            end else begin
              coin_return <= 1'b1;
            end
          end
        end
        MONEY: begin
          if (cancel) begin
            st          <= REFUND;
            coin_return <= coin_any;
          end else if (sel_valid) begin
            coin_return <= coin_any;
            if (afford) begin
              st            <= PURCHASED;
              balance       <= balance - price;
              dispense      <= 1'b1;
              dispense_type <= sel_type;
            end else begin
              st     <= REJECTION;
              reject <= 1'b1;
            end
          end else begin
            balance     <= bal_credit;
            coin_return <= coin_any && !coin_fits;
          end
        end
        PURCHASED: begin
          coin_return <= coin_any;
          st          <= (balance != 5'd0) ? REFUND : INIT;
        end
        REJECTION: begin
          if (cancel) begin
            st          <= REFUND;
            reject      <= 1'b0;
            coin_return <= coin_any;
          end else begin
            balance     <= bal_credit;
            coin_return <= coin_any && !coin_fits;
            if (hold_done) begin
              reject <= 1'b0;
              st     <= (bal_credit != 5'd0) ? MONEY : INIT;
            end
          end
        end
        REFUND: begin
          coin_return <= coin_any;
          if (balance >= 5'd2) begin
            change_dime <= 1'b1;
            balance     <= balance - 5'd2;
            if (balance == 5'd2) st <= INIT;
          end else if (balance == 5'd1) begin
            change_nickel <= 1'b1;
            balance       <= 5'd0;
            st            <= INIT;
          end else begin
            st <= INIT;
          end
        end
        default: begin
          st     <= INIT;
          reject <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm.sv
// Self-checking bench for vend_fsm: vector table, directed corner cases,
// then random traffic against a transaction-level reference model.
module tb_vend_fsm;

  localparam int MAX_BAL     = 30;
  localparam int REJECT_HOLD = 100;

  logic       hz100 = 1'b0;
  logic       reset = 1'b0;
  logic       coin_nickel = 1'b0;
  logic       coin_dime = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_cost = 2'd0;
  logic [1:0] sel_type = 2'd0;
  logic       cancel = 1'b0;
  logic [2:0] state;
  logic [4:0] balance;
  logic       dispense;
  logic [1:0] dispense_type;
  logic       reject;
  logic       coin_return;
  logic       change_dime;
  logic       change_nickel;

  vend_fsm #(
    .MAX_BAL     (MAX_BAL),
    .REJECT_HOLD (REJECT_HOLD)
  ) dut (
    .hz100         (hz100),
    .reset         (reset),
    .coin_nickel   (coin_nickel),
    .coin_dime     (coin_dime),
    .sel_valid     (sel_valid),
    .sel_cost      (sel_cost),
    .sel_type      (sel_type),
    .cancel        (cancel),
    .state         (state),
    .balance       (balance),
    .dispense      (dispense),
    .dispense_type (dispense_type),
    .reject        (reject),
    .coin_return   (coin_return),
    .change_dime   (change_dime),
    .change_nickel (change_nickel)
  );

  always #5 hz100 = ~hz100;

  typedef struct packed {
    bit       rst;
    bit       cn;
    bit       cd;
    bit       sv;
    bit [1:0] cost;
    bit [1:0] typ;
    bit       can;
  } stim_t;

  typedef struct {
    stim_t s;
    int    st, bal, disp, dtype, rej, cret, cd, cn;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: mode, credit, latched type, remaining hold cycles,
  // and the list of change coins still owed (2 = dime, 1 = nickel).
  int m_state = 0, m_bal = 0, m_dtype = 0, m_hold = 0;
  int e_disp = 0, e_cret = 0, e_cd = 0, e_cn = 0;
  int chg[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk_s(bit rst, bit cn, bit cd, bit sv, bit [1:0] cost,
                                 bit [1:0] typ, bit can);
    stim_t s;
    s.rst = rst; s.cn = cn; s.cd = cd; s.sv = sv;
    s.cost = cost; s.typ = typ; s.can = can;
    return s;
  endfunction

  function automatic vec_t mk_v(stim_t s, int st, int bal, int disp, int dtype,
                                int rej, int cret, int cd, int cn);
    vec_t v;
    v.s = s; v.st = st; v.bal = bal; v.disp = disp; v.dtype = dtype;
    v.rej = rej; v.cret = cret; v.cd = cd; v.cn = cn;
    return v;
  endfunction

  task automatic plan_refund();
    chg.delete();
    for (int i = 0; i < m_bal / 2; i++) chg.push_back(2);
    if (m_bal % 2 == 1) chg.push_back(1);
  endtask

  // All-or-nothing credit; returns 1 if the coins were taken.
  function automatic bit try_credit(int v);
    if (v == 0) return 1'b0;
    if (m_bal + v <= MAX_BAL) begin
      m_bal += v;
      return 1'b1;
    end
    e_cret = 1;
    return 1'b0;
  endfunction

  task automatic model_step(input stim_t s);
    int v;
    int price;
    int c;
    v = int'(s.cn) + 2 * int'(s.cd);
    e_disp = 0; e_cret = 0; e_cd = 0; e_cn = 0;
    if (s.rst) begin
      m_state = 0; m_bal = 0; m_dtype = 0; m_hold = 0;
      chg.delete();
      return;
    end
    case (m_state)
      0, 1: begin
        if (m_state == 1 && s.can) begin
          e_cret = (v > 0);
          m_state = 4;
          plan_refund();
        end else if (s.sv) begin
          e_cret = (v > 0);
          price = 5 * (int'(s.cost) + 1);
          if (price <= m_bal) begin
            m_bal -= price;
            m_dtype = int'(s.typ);
            m_state = 2;
            e_disp = 1;
          end else begin
            m_state = 3;
            m_hold = REJECT_HOLD;
          end
        end else if (try_credit(v)) begin
          m_state = 1;
        end
      end
      2: begin
        e_cret = (v > 0);
        if (m_bal > 0) begin
          m_state = 4;
          plan_refund();
        end else begin
          m_state = 0;
        end
      end
      3: begin
        if (s.can) begin
          e_cret = (v > 0);
          m_state = 4;
          plan_refund();
        end else begin
          void'(try_credit(v));
          m_hold--;
          if (m_hold == 0) m_state = (m_bal > 0) ? 1 : 0;
        end
      end
      default: begin
        e_cret = (v > 0);
        if (chg.size() > 0) begin
          c = chg.pop_front();
          m_bal -= c;
          if (c == 2) e_cd = 1; else e_cn = 1;
        end
        if (chg.size() == 0) m_state = 0;
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic tick(input stim_t s);
    reset       = s.rst;
    coin_nickel = s.cn;
    coin_dime   = s.cd;
    sel_valid   = s.sv;
    sel_cost    = s.cost;
    sel_type    = s.typ;
    cancel      = s.can;
    @(posedge hz100);
    model_step(s);
    #1;
    check("m_state", 32'(state), m_state);
    check("m_balance", 32'(balance), m_bal);
    check("m_dispense", 32'(dispense), e_disp);
    check("m_dispense_type", 32'(dispense_type), m_dtype);
    check("m_reject", 32'(reject), (m_state == 3) ? 1 : 0);
    check("m_coin_return", 32'(coin_return), e_cret);
    check("m_change_dime", 32'(change_dime), e_cd);
    check("m_change_nickel", 32'(change_nickel), e_cn);
  endtask

  stim_t idle, rst_s, nk, dm, both, can_s;
  vec_t  tbl[$];
  int    cnt;

  initial begin
    idle  = mk_s(0, 0, 0, 0, 2'd0, 2'd0, 0);
    rst_s = mk_s(1, 0, 0, 0, 2'd0, 2'd0, 0);
    nk    = mk_s(0, 1, 0, 0, 2'd0, 2'd0, 0);
    dm    = mk_s(0, 0, 1, 0, 2'd0, 2'd0, 0);
    both  = mk_s(0, 1, 1, 0, 2'd0, 2'd0, 0);
    can_s = mk_s(0, 0, 0, 0, 2'd0, 2'd0, 1);

    // ---- Vector table: {stimulus, state, bal, disp, dtype, rej, cret, cd, cn}
    tbl.push_back(mk_v(rst_s, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk_v(dm, 1, 2 * k, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk_v(mk_s(0, 0, 0, 1, 2'd1, 2'd2, 0), 2, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk_v(idle, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk_v(mk_s(0, 1, 0, 1, 2'd0, 2'd1, 0), 3, 0, 0, 2, 1, 1, 0, 0));
    tbl.push_back(mk_v(can_s, 4, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk_v(idle, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk_v(nk, 1, 1, 0, 2, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++) tbl.push_back(mk_v(dm, 1, 1 + 2 * k, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk_v(mk_s(0, 0, 0, 1, 2'd1, 2'd3, 0), 2, 3, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk_v(dm, 4, 3, 0, 3, 0, 1, 0, 0));
    tbl.push_back(mk_v(idle, 4, 1, 0, 3, 0, 0, 1, 0));
    tbl.push_back(mk_v(idle, 0, 0, 0, 3, 0, 0, 0, 1));
    tbl.push_back(mk_v(mk_s(0, 1, 0, 0, 2'd0, 2'd0, 1), 1, 1, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk_v(mk_s(0, 0, 0, 1, 2'd0, 2'd1, 0), 3, 1, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk_v(mk_s(0, 0, 1, 1, 2'd0, 2'd1, 0), 3, 3, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk_v(can_s, 4, 3, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk_v(idle, 4, 1, 0, 3, 0, 0, 1, 0));
    tbl.push_back(mk_v(idle, 0, 0, 0, 3, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      tick(tbl[i].s);
      check($sformatf("vec%0d_state", i), 32'(state), tbl[i].st);
      check($sformatf("vec%0d_balance", i), 32'(balance), tbl[i].bal);
      check($sformatf("vec%0d_dispense", i), 32'(dispense), tbl[i].disp);
      check($sformatf("vec%0d_dtype", i), 32'(dispense_type), tbl[i].dtype);
      check($sformatf("vec%0d_reject", i), 32'(reject), tbl[i].rej);
      check($sformatf("vec%0d_coin_return", i), 32'(coin_return), tbl[i].cret);
      check($sformatf("vec%0d_change_dime", i), 32'(change_dime), tbl[i].cd);
      check($sformatf("vec%0d_change_nickel", i), 32'(change_nickel), tbl[i].cn);
    end

    // ---- Rejection hold: balance 7, price 10 -> reject for exactly 100 cycles.
    tick(rst_s);
    tick(dm); tick(dm); tick(dm); tick(nk);
    check("rej_pre_balance", 32'(balance), 7);
    tick(mk_s(0, 0, 0, 1, 2'd1, 2'd0, 0));
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (reject !== 1'b1) break;
      cnt++;
      tick(idle);
    end
    check("rej_hold_cycles", cnt, REJECT_HOLD);
    check("rej_exit_state", 32'(state), 1);
    check("rej_exit_balance", 32'(balance), 7);

    // ---- Credit ceiling at 29/30.
    tick(rst_s);
    for (int i = 0; i < 14; i++) tick(dm);
    tick(nk);
    check("cap_balance29", 32'(balance), 29);
    tick(dm);
    check("cap_dime_return", 32'(coin_return), 1);
    check("cap_dime_balance", 32'(balance), 29);
    tick(both);
    check("cap_both_return", 32'(coin_return), 1);
    check("cap_both_balance", 32'(balance), 29);
    tick(nk);
    check("cap_nickel_return", 32'(coin_return), 0);
    check("cap_nickel_balance", 32'(balance), 30);
    tick(nk);
    check("cap_full_return", 32'(coin_return), 1);
    check("cap_full_balance", 32'(balance), 30);

    // ---- Cancel with balance 5; a coin in REFUND is returned.
    tick(rst_s);
    tick(nk); tick(dm); tick(dm);
    tick(can_s);
    check("cancel_state", 32'(state), 4);
    tick(dm);
    check("refund1_dime", 32'(change_dime), 1);
    check("refund1_coin_return", 32'(coin_return), 1);
    check("refund1_balance", 32'(balance), 3);
    tick(idle);
    check("refund2_dime", 32'(change_dime), 1);
    tick(idle);
    check("refund3_nickel", 32'(change_nickel), 1);
    check("refund3_state", 32'(state), 0);

    // ---- Reset in the second REFUND cycle with balance 8.
    tick(rst_s);
    for (int i = 0; i < 4; i++) tick(dm);
    tick(can_s);
    tick(idle);
    check("rstmid_pre_balance", 32'(balance), 6);
    tick(rst_s);
    check("rstmid_state", 32'(state), 0);
    check("rstmid_balance", 32'(balance), 0);
    for (int i = 0; i < 4; i++) begin
      tick(idle);
      check("rstmid_no_dime", 32'(change_dime), 0);
      check("rstmid_no_nickel", 32'(change_nickel), 0);
    end

    // ---- Random traffic against the model.
    tick(rst_s);
    for (int i = 0; i < 4000; i++) begin
      stim_t s;
      s.rst  = ($urandom_range(0, 999) < 3);
      s.cn   = ($urandom_range(0, 99) < 20);
      s.cd   = ($urandom_range(0, 99) < 20);
      s.sv   = ($urandom_range(0, 99) < 6);
      s.cost = 2'($urandom_range(0, 3));
      s.typ  = 2'($urandom_range(0, 3));
      s.can  = ($urandom_range(0, 99) < 3);
      tick(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
